// File: rtl/ysyx_23060332_imem_resp.sv
// Instruction-memory responder: accepts one fetch at a time and returns the
// addressed word (or an access fault) after a fixed latency.
module ysyx_23060332_imem_resp #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = 30;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   mem [DEPTH];

    logic [IW-1:0] req_idx_c;
    logic [IW-1:0] load_idx_c;
    logic          req_fault_c;
    logic          load_fault_c;

    // Word index relative to BASE_ADDR; addresses below base wrap high and fault.
    assign req_idx_c    = IW'((req_addr - BASE_ADDR) >> 2);
    assign load_idx_c   = IW'((load_addr - BASE_ADDR) >> 2);
    assign req_fault_c  = (req_addr[1:0] != 2'b00) || (req_idx_c >= IW'(DEPTH));
    assign load_fault_c = (load_addr[1:0] != 2'b00) || (load_idx_c >= IW'(DEPTH));

    // Preload port; array is not reset and faulting loads are dropped.
    always_ff @(posedge clk) begin
        if (load_en && !load_fault_c) begin
            mem[load_idx_c[AW-1:0]] <= load_data;
        end
    end

    // Request/response FSM with registered handshake and payload outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        // Array read here sees the pre-edge contents (read-before-write).
                        rsp_data  <= req_fault_c ? 32'h0 : mem[req_idx_c[AW-1:0]];
                        rsp_err   <= req_fault_c;
                        cnt       <= CW'(LATENCY - 1);
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_imem_resp.sv
// Self-checking bench: two responders (latency 2 and 1) sharing load/reset,
// checked against a transaction-level memory model.
module tb_ysyx_23060332_imem_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid_a, req_valid_b;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        load_en;
    logic [31:0] load_addr, load_data;
    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_data_a, rsp_data_b;

    bit          sel;
    logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
    logic [31:0] cur_rsp_data;

    assign cur_req_ready = sel ? req_ready_b : req_ready_a;
    assign cur_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign cur_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
    assign cur_rsp_data  = sel ? rsp_data_b  : rsp_data_a;

    ysyx_23060332_imem_resp #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_data(rsp_data_a), .rsp_err(rsp_err_a),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    ysyx_23060332_imem_resp #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [int];

    typedef struct {
        logic [31:0] addr;
        int          hold;
        bit          err;
        logic [31:0] data;
    } vec_t;

    vec_t vt [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Byte-level model of the decode: in range iff aligned and offset < 4*DEPTH.
    function automatic void model(input logic [31:0] addr, output bit err, output logic [31:0] data);
        logic [31:0] off;
        off = addr - BASE;
        if (addr % 4 != 0 || off >= 32'(4 * DEPTH)) begin
            err  = 1'b1;
            data = 32'h0;
        end else begin
            err  = 1'b0;
            data = ref_mem.exists(int'(off / 4)) ? ref_mem[int'(off / 4)] : 32'h0;
        end
    endfunction

    function automatic void model_load(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off;
        off = addr - BASE;
        if (addr % 4 == 0 && off < 32'(4 * DEPTH)) ref_mem[int'(off / 4)] = data;
    endfunction

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        step();
        load_en = 1'b0;
        model_load(addr, data);
    endtask

    // One full fetch on instance s, optionally colliding with a load at the accept edge.
    task automatic fetch(input bit s, input logic [31:0] addr, input int hold,
                         input bit col, input logic [31:0] cdata,
                         input bit eerr, input logic [31:0] edata);
        int n;
        int lat;
        rsp_ready = 1'b0;
        sel = s;
        #0;
        n = 0;
        while (!cur_req_ready && n < 20) begin
            step();
            n++;
        end
        if (!cur_req_ready) begin
            check("req_ready_timeout", 32'(cur_req_ready), 32'd1);
            return;
        end
        if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        req_addr = addr;
        if (col) begin
            load_en   = 1'b1;
            load_addr = addr;
            load_data = cdata;
        end
        step();
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        load_en     = 1'b0;
        req_addr    = $urandom;
        if (col) model_load(addr, cdata);
        lat = 1;
        while (!cur_rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), s ? 32'd1 : 32'd2);
        if (!cur_rsp_valid) return;
        check("rsp_err", 32'(cur_rsp_err), 32'(eerr));
        check("rsp_data", cur_rsp_data, edata);
        for (int k = 0; k < hold; k++) begin
            req_addr = $urandom;
            step();
            check("hold_valid", 32'(cur_rsp_valid), 32'd1);
            check("hold_data", cur_rsp_data, edata);
            check("hold_err", 32'(cur_rsp_err), 32'(eerr));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("valid_cleared", 32'(cur_rsp_valid), 32'd0);
        check("ready_back", 32'(cur_req_ready), 32'd1);
    endtask

    initial begin
        bit          e;
        logic [31:0] d;
        logic [31:0] a;
        int          cat;
        int          r;
        bit          col;

        vt[0] = '{32'h8000_0000, 0, 1'b0, 32'h0000_0413};
        vt[1] = '{32'h8000_0004, 5, 1'b0, 32'h0010_0093};
        vt[2] = '{32'h8000_0002, 0, 1'b1, 32'h0};
        vt[3] = '{32'h8000_1000, 0, 1'b1, 32'h0};
        vt[4] = '{32'h7FFF_FFFC, 1, 1'b1, 32'h0};
        vt[5] = '{32'h8000_0FFC, 0, 1'b0, 32'hDEAD_BEEF};

        sel = 1'b0;
        rst = 1'b0;
        req_valid_a = 1'b1;
        req_valid_b = 1'b1;
        req_addr  = 32'h8000_0000;
        rsp_ready = 1'b1;
        load_en   = 1'b0;
        load_addr = 32'h0;
        load_data = 32'h0;

        // Reset holds outputs low even with a request pending.
        step();
        step();
        check("rst_req_ready_a", 32'(req_ready_a), 32'd0);
        check("rst_req_ready_b", 32'(req_ready_b), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("rst_rsp_data", rsp_data_a, 32'd0);
        check("rst_rsp_err", 32'(rsp_err_a), 32'd0);
        load(32'h8000_0000, 32'h0000_0413);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        rst = 1'b1;
        step();
        check("release_ready", 32'(req_ready_a), 32'd1);
        check("release_valid", 32'(rsp_valid_a), 32'd0);

        // Preload program words; faulting loads must be dropped.
        for (int i = 3; i < 16; i++) load(BASE + 32'(4 * i), $urandom);
        load(32'h8000_0004, 32'h0010_0093);
        load(32'h8000_0008, 32'hAAAA_AAAA);
        load(32'h8000_0FFC, 32'hDEAD_BEEF);
        load(32'h8000_0001, 32'h1111_1111);
        load(32'h7FFF_FFFC, 32'h2222_2222);
        load(32'h8000_1000, 32'h3333_3333);

        // Table vectors on the latency-2 instance.
        for (int i = 0; i < 6; i++) begin
            fetch(1'b0, vt[i].addr, vt[i].hold, 1'b0, 32'h0, vt[i].err, vt[i].data);
        end

        // Read/load collision: old word returned, new word seen next time.
        fetch(1'b0, 32'h8000_0008, 0, 1'b1, 32'h5555_5555, 1'b0, 32'hAAAA_AAAA);
        fetch(1'b0, 32'h8000_0008, 0, 1'b0, 32'h0, 1'b0, 32'h5555_5555);

        // Reset while waiting discards the transaction.
        sel = 1'b0;
        req_valid_a = 1'b1;
        req_addr = 32'h8000_0004;
        step();
        req_valid_a = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(rsp_valid_a), 32'd0);
        check("midrst_ready", 32'(req_ready_a), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        check("postrst_ready", 32'(req_ready_a), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("postrst_no_rsp", 32'(rsp_valid_a), 32'd0);
            step();
        end
        fetch(1'b0, 32'h8000_0000, 0, 1'b0, 32'h0, 1'b0, 32'h0000_0413);

        // Latency-1 instance: directed then mixed.
        fetch(1'b1, 32'h8000_0000, 0, 1'b0, 32'h0, 1'b0, 32'h0000_0413);
        fetch(1'b1, 32'h8000_0004, 2, 1'b0, 32'h0, 1'b0, 32'h0010_0093);
        fetch(1'b1, 32'h8000_0002, 0, 1'b0, 32'h0, 1'b1, 32'h0);

        // Randomized fetches against the model.
        for (int i = 0; i < 30; i++) begin
            cat = $urandom_range(0, 4);
            r   = $urandom_range(0, 15);
            case (cat)
                3:       a = BASE + 32'(4 * r) + 32'($urandom_range(1, 3));
                4:       a = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * DEPTH) + 32'(4 * r)
                                                          : BASE - 32'(4 * (r + 1));
                default: a = BASE + 32'(4 * r);
            endcase
            if ($urandom_range(0, 3) == 0) load(BASE + 32'(4 * $urandom_range(3, 15)), $urandom);
            col = ($urandom_range(0, 3) == 0);
            model(a, e, d);
            fetch(1'($urandom_range(0, 1)), a, $urandom_range(0, 3), col, $urandom, e, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060332_imem_resp.md
Name: ysyx_23060332_imem_resp

Overview:
Instruction-memory responder that services fetch requests from the IFU: the memory side of the instruction-fetch interface. Holds a word-addressed instruction array and accepts one request at a time over a valid/ready channel. Returns the word after a programmable latency over a valid/ready response channel, flagging misaligned or out-of-range addresses. A side load port lets the bench or loader preload the program.

Parameters:
BASE_ADDR, 32'h80000000, byte address of array word 0 (reset PC target)
DEPTH, 1024, number of 32-bit words; power of two
LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
req_valid  in  1  fetch request present
req_ready  out  1  responder can accept a request
req_addr  in  32  fetch byte address
rsp_valid  out  1  response word present
rsp_ready  in  1  IFU accepts response
rsp_data  out  32  instruction word
rsp_err  out  1  access fault for this response
load_en  in  1  write one word into the array
load_addr  in  32  byte address for load (same decode as req_addr)
load_data  in  32  word to write

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, req_ready=0 while rst=0, rsp_valid=0, rsp_data=0, rsp_err=0, latency counter=0. Array contents are not reset. Reset mid-WAIT or mid-RESP discards the transaction; no response is produced.
- FSM states:
  - IDLE: req_ready=1 (once rst=1). On req_valid&&req_ready at edge E0: latch address check result and array word, load counter with LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
  - WAIT: req_ready=0. Counter decrements each edge; on the edge where the counter is 1, go to RESP. rsp_valid therefore first seen high in the cycle after edge E0+LATENCY-1, i.e. LATENCY cycles after the accept cycle.
  - RESP: rsp_valid=1; rsp_data and rsp_err stable until handshake. On rsp_valid&&rsp_ready at an edge, go to IDLE and clear rsp_valid. If rsp_ready stays low, hold indefinitely.
- No overlap: a new request is accepted only in IDLE. Minimum period is LATENCY+1 cycles per fetch with rsp_ready tied high.
- Address decode: offset = addr - BASE_ADDR (32-bit wrap); index = offset[31:2].
  - Fault if addr[1:0]!=0 or index >= DEPTH; addresses below BASE_ADDR wrap to large offsets and fault.
  - On fault: rsp_err=1, rsp_data=32'h0. Otherwise rsp_err=0, rsp_data=array[index].
- Data is sampled at the accept edge (read-before-write). A load_en to the same index at the same edge does not affect that response; it does affect later requests.
- Load port: when load_en=1 and load_addr decodes in range and aligned, array[index] <= load_data at the edge. Faulting load addresses are silently dropped. Loads are accepted in any state, including during reset deassertion.
- req_addr is ignored outside the accept edge; changes while req_ready=0 have no effect.
- The error check is combinational on req_addr; only the latched result reaches outputs.

Test Plan:
- Reset/idle: hold rst=0 with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0. Release rst -> req_ready=1 next cycle.
- Basic fetch, LATENCY=2:
  - Stimulus: load 0x80000000<=32'h00000413, request 0x80000000 accepted at cycle 0, rsp_ready=1.
  - Response: rsp_valid high in cycle 2 only, rsp_data=32'h00000413, rsp_err=0, req_ready high again in cycle 3.
- Backpressure: request 0x80000004 (loaded 32'h00100093), rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held constant 5 cycles. Single handshake on rsp_ready=1, then IDLE.
- Faults:
  - 0x80000002 -> rsp_err=1, data 0.
  - 0x80000000+4*DEPTH -> rsp_err=1.
  - 0x7FFFFFFC -> rsp_err=1.
  - 0x80000000+4*(DEPTH-1) -> rsp_err=0.
- Read/load collision: accept request to 0x80000008 (old 32'hAAAAAAAA) with load_en writing 32'h55555555 same edge -> rsp_data=32'hAAAAAAAA. The next fetch of the same address returns 32'h55555555.
- Reset mid-operation: accept request, assert rst during WAIT -> rsp_valid never rises. After release, a fresh fetch of 0x80000000 returns correct data with full LATENCY. Repeat with LATENCY=1: response is in the cycle after accept.
